// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo I2S / left-justified serial audio transmitter with sample FIFO.
//   clk_audio_bit_i  bit clock, all logic on its rising edge
//   reset_n_i        asynchronous active-low reset
//   enable_i         transmit enable, sampled at frame boundaries only
//   sample_l_i/r_i   stereo frame offered by the producer
//   sample_valid_i   producer handshake; accepted when sample_ready_o is high
//   sample_ready_o   FIFO not full
//   fifo_level_o     frames currently held
//   underrun_o       one-cycle pulse after a frame started with an empty FIFO
//   audio_data_o     serial data, MSB first, zero padded
//   audio_ws_o       word select, 0 = left slot, 1 = right slot
module audio_i2s_tx #(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int SLOT_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int I2S_MODE      = 1,
  parameter int UNDERRUN_MUTE = 1
) (
  input  logic                          clk_audio_bit_i,
  input  logic                          reset_n_i,
  input  logic                          enable_i,
  input  logic [SAMPLE_WIDTH-1:0]       sample_l_i,
  input  logic [SAMPLE_WIDTH-1:0]       sample_r_i,
  input  logic                          sample_valid_i,
  output logic                          sample_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underrun_o,
  output logic                          audio_data_o,
  output logic                          audio_ws_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 2 * SLOT_WIDTH;
  localparam int CW = $clog2(FW);
  localparam int SHIFT = SLOT_WIDTH - SAMPLE_WIDTH - I2S_MODE;
  localparam logic [CW-1:0] CNT_HALF = CW'(SLOT_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] sh_q, sh_d, src;
  logic [SLOT_WIDTH-1:0] slot_l, slot_r;
  logic [SAMPLE_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] last_l_q, last_r_q, new_l, new_r;
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic data_d, ws_d, underrun_d, empty, push, pop, frame_start, active;
  assign fifo_level_o = level_q;
  // The whole frame lives in one shift register whose MSB is the next bit out;
  // each slot is pre-positioned so the I2S delay and zero padding fall out naturally.
  always_comb begin
    empty          = level_q == '0;
    sample_ready_o = level_q != LVL_FULL;
    push           = sample_valid_i && sample_ready_o;
    frame_start    = enable_i && (state_q == IDLE || cnt_q == '0);
    pop            = frame_start && !empty;
    underrun_d     = frame_start && empty;
    active         = frame_start || (state_q == RUN && cnt_q != '0);
    new_l          = !empty ? mem_l[rd_q] : (UNDERRUN_MUTE != 0 ? '0 : last_l_q);
    new_r          = !empty ? mem_r[rd_q] : (UNDERRUN_MUTE != 0 ? '0 : last_r_q);
    slot_l         = SLOT_WIDTH'(new_l) << SHIFT;
    slot_r         = SLOT_WIDTH'(new_r) << SHIFT;
    src            = frame_start ? {slot_l, slot_r} : sh_q;
    sh_d           = active ? src << 1 : sh_q;
    data_d         = active && src[FW-1];
    ws_d           = active && cnt_q >= CNT_HALF;
    cnt_d          = (!active || cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    state_d        = active ? RUN : IDLE;
    level_d        = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk_audio_bit_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      last_l_q     <= '0;
      last_r_q     <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      level_q      <= '0;
      audio_data_o <= 1'b0;
      audio_ws_o   <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      level_q      <= level_d;
      audio_data_o <= data_d;
      audio_ws_o   <= ws_d;
      underrun_o   <= underrun_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q     <= rd_q + AW'(1);
        last_l_q <= new_l;
        last_r_q <= new_r;
      end
    end
  end
  always_ff @(posedge clk_audio_bit_i) begin
    if (push) begin
      mem_l[wr_q] <= sample_l_i;
      mem_r[wr_q] <= sample_r_i;
    end
  end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: table-driven check of an I2S/16-bit/mute instance and a LJ/24-bit/repeat instance.
module tb_audio_i2s_tx;
  typedef struct packed {
    logic [15:0] l, r;
    logic [23:0] l24, r24;
    logic [63:0] e16, e24;
  } vec_t;
  localparam logic [63:0] WS_EXP = 64'h0000_0000_FFFF_FFFF;
  logic clk, reset_n, enable, valid;
  logic [15:0] sl, sr;
  logic [23:0] sl24, sr24;
  logic rdy16, rdy24, un16, un24, d16, d24, ws16, ws24;
  logic [2:0] lvl16, lvl24;
  int checks, errors;
  vec_t tbl [5];
  audio_i2s_tx u16 (
    .clk_audio_bit_i(clk), .reset_n_i(reset_n), .enable_i(enable),
    .sample_l_i(sl), .sample_r_i(sr), .sample_valid_i(valid),
    .sample_ready_o(rdy16), .fifo_level_o(lvl16), .underrun_o(un16),
    .audio_data_o(d16), .audio_ws_o(ws16)
  );
  audio_i2s_tx #(.SAMPLE_WIDTH(24), .I2S_MODE(0), .UNDERRUN_MUTE(0)) u24 (
    .clk_audio_bit_i(clk), .reset_n_i(reset_n), .enable_i(enable),
    .sample_l_i(sl24), .sample_r_i(sr24), .sample_valid_i(valid),
    .sample_ready_o(rdy24), .fifo_level_o(lvl24), .underrun_o(un24),
    .audio_data_o(d24), .audio_ws_o(ws24)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic load(input int i);
    sl = tbl[i].l; sr = tbl[i].r; sl24 = tbl[i].l24; sr24 = tbl[i].r24;
  endtask
  task automatic run_frame(input int f, output logic [63:0] o16, output logic [63:0] o24,
                           output logic [63:0] w16, output logic [63:0] w24, output int up);
    up = 0;
    for (int p = 0; p < 64; p++) begin
      o16[63-p] = d16; o24[63-p] = d24; w16[63-p] = ws16; w24[63-p] = ws24;
      up += int'(un16) + int'(un24);
      if (f == 0 && p == 0) begin
        chk("level_after_pop16", 64'(lvl16), 64'd3);
        chk("level_after_pop24", 64'(lvl24), 64'd3);
        chk("ready_after_pop", 64'(rdy16), 64'd1);
      end
      if (f == 0 && p == 1) begin
        chk("level_held_push", 64'(lvl16), 64'd4);
        valid = 1'b0;
      end
      if (f == 6 && p == 10) enable = 1'b0;
      @(negedge clk);
    end
  endtask
  initial begin
    logic [63:0] o16, o24, w16, w24;
    int up;
    checks = 0; errors = 0;
    tbl[0] = '{16'hA5A5, 16'h0F0F, 24'h800001, 24'h7FFFFE, 64'h52D28000_07878000, 64'h80000100_7FFFFE00};
    tbl[1] = '{16'h8001, 16'h7FFE, 24'hFFFFFF, 24'h000000, 64'h40008000_3FFF0000, 64'hFFFFFF00_00000000};
    tbl[2] = '{16'hFFFF, 16'h0000, 24'h123456, 24'hABCDEF, 64'h7FFF8000_00000000, 64'h12345600_ABCDEF00};
    tbl[3] = '{16'h0001, 16'h8000, 24'h000001, 24'h800000, 64'h00008000_40000000, 64'h00000100_80000000};
    tbl[4] = '{16'h1234, 16'hFEDC, 24'hA5A5A5, 24'h0F0F0F, 64'h091A0000_7F6E0000, 64'hA5A5A500_0F0F0F00};
    reset_n = 1'b0; enable = 1'b0; valid = 1'b0;
    sl = '0; sr = '0; sl24 = '0; sr24 = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", {62'd0, d16, d24}, 64'd0);
    chk("rst_ws", {62'd0, ws16, ws24}, 64'd0);
    chk("rst_underrun", {62'd0, un16, un24}, 64'd0);
    chk("rst_level", {58'd0, lvl16, lvl24}, 64'd0);
    chk("rst_ready", {62'd0, rdy16, rdy24}, 64'd3);
    reset_n = 1'b1;
    @(negedge clk);
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load(i);
      @(negedge clk);
      chk($sformatf("prefill_level%0d", i), 64'(lvl16), 64'(i + 1));
      chk($sformatf("prefill_level24_%0d", i), 64'(lvl24), 64'(i + 1));
    end
    chk("full_ready", {62'd0, rdy16, rdy24}, 64'd0);
    load(4);
    @(negedge clk);
    chk("full_no_push", 64'(lvl16), 64'd4);
    chk("idle_data", {62'd0, d16, ws16}, 64'd0);
    enable = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 7; f++) begin
      run_frame(f, o16, o24, w16, w24, up);
      chk($sformatf("frame%0d_data16", f), o16, f < 5 ? tbl[f].e16 : 64'd0);
      chk($sformatf("frame%0d_data24", f), o24, f < 5 ? tbl[f].e24 : tbl[4].e24);
      chk($sformatf("frame%0d_ws16", f), w16, WS_EXP);
      chk($sformatf("frame%0d_ws24", f), w24, WS_EXP);
      chk($sformatf("frame%0d_underruns", f), 64'(up), f < 5 ? 64'd0 : 64'd2);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stopped_out%0d", i), {60'd0, d16, d24, ws16, ws24}, 64'd0);
      chk($sformatf("stopped_underrun%0d", i), {62'd0, un16, un24}, 64'd0);
      @(negedge clk);
    end
    valid = 1'b1;
    load(1);
    @(negedge clk);
    load(2);
    @(negedge clk);
    valid = 1'b0;
    chk("pre_rst_level", 64'(lvl16), 64'd2);
    enable = 1'b1;
    repeat (41) @(negedge clk);
    chk("pre_rst_ws", {62'd0, ws16, ws24}, 64'd3);
    reset_n = 1'b0;
    #1;
    chk("midrst_out", {60'd0, d16, d24, ws16, ws24}, 64'd0);
    chk("midrst_level", {58'd0, lvl16, lvl24}, 64'd0);
    chk("midrst_ready", {62'd0, rdy16, rdy24}, 64'd3);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_frame(7, o16, o24, w16, w24, up);
    chk("post_rst_data16", o16, 64'd0);
    chk("post_rst_data24", o24, 64'd0);
    chk("post_rst_ws", w16 & w24, WS_EXP);
    chk("post_rst_underruns", 64'(up), 64'd2);
    enable = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
